// File: rtl/display_7s_page_ctrl_if.sv
// Page-controller bus: timebase, page enables and buttons in; page select, change strobe and blanking out.
interface display_7s_page_ctrl_if;
  logic       tick;
  logic [7:0] ch_en;
  logic       auto_en;
  logic       btn_next;
  logic       btn_prev;
  logic [2:0] sel;
  logic       page_change;
  logic       blank;

  modport master (
    output tick, ch_en, auto_en, btn_next, btn_prev,
    input  sel, page_change, blank
  );

  modport slave (
    input  tick, ch_en, auto_en, btn_next, btn_prev,
    output sel, page_change, blank
  );
endinterface

// File: rtl/display_7s_page_ctrl.sv
// 8-page seven-segment display page selector: buttons, auto-advance dwell, skip of disabled pages.
// Optional blanking interval after each page change is compiled in with DISPLAY_7S_PAGE_BLANK_EN.
module display_7s_page_ctrl #(
  parameter int DWELL_TICKS = 2000,
  parameter int BLANK_TICKS = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  display_7s_page_ctrl_if.slave  io
);

  if (DWELL_TICKS < 1 || DWELL_TICKS > 65535 || BLANK_TICKS < 1 || BLANK_TICKS > 65535) begin : g_param_chk
    $error("display_7s_page_ctrl: DWELL_TICKS/BLANK_TICKS out of range 1..65535");
  end

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // First enabled page strictly after cur (wrapping); cur itself if no other page is enabled.
  function automatic logic [2:0] next_page(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      idx = cur + 3'(i);
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] prev_page(input logic [2:0] cur, input logic [7:0] en);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      idx = cur - 3'(i);
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [2:0]  sel_q, sel_d;
  logic        pc_q, pc_d;
  logic [15:0] dwell_q, dwell_d;
  logic [2:0]  target;
  logic        dwell_hit;
  logic        in_show;

`ifdef DISPLAY_7S_PAGE_BLANK_EN
  logic [0:0]  state_q, state_d;
  logic [15:0] bcnt_q, bcnt_d;
`endif

  always_comb begin
    sel_d     = sel_q;
    pc_d      = 1'b0;
    dwell_d   = dwell_q;
    target    = sel_q;
    dwell_hit = io.tick && (dwell_q == 16'(DWELL_TICKS - 1));
`ifdef DISPLAY_7S_PAGE_BLANK_EN
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    in_show   = (state_q == ST_SHOW);
`else
    in_show   = 1'b1;
`endif

    if (in_show) begin
      if (!io.auto_en) begin
        dwell_d = 16'd0;
      end else if (io.tick) begin
        dwell_d = dwell_hit ? 16'd0 : dwell_q + 16'd1;
      end
      // Priority: forced skip > next > prev > dwell; simultaneous buttons cancel each other.
      if (io.ch_en != 8'h00) begin
        if (!io.ch_en[sel_q]) begin
          target = next_page(sel_q, io.ch_en);
        end else if (io.btn_next && !io.btn_prev) begin
          target = next_page(sel_q, io.ch_en);
        end else if (io.btn_prev && !io.btn_next) begin
          target = prev_page(sel_q, io.ch_en);
        end else if (io.auto_en && dwell_hit) begin
          target = next_page(sel_q, io.ch_en);
        end
      end
    end
`ifdef DISPLAY_7S_PAGE_BLANK_EN
    else begin
      dwell_d = 16'd0;
      if (io.tick) begin
        if (bcnt_q == 16'(BLANK_TICKS - 1)) begin
          state_d = ST_SHOW;
          bcnt_d  = 16'd0;
        end else begin
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
    end
`endif

    // An all-zero mask parks on page 0 silently, even mid-blank.
    if (io.ch_en == 8'h00) begin
      sel_d   = 3'd0;
      dwell_d = 16'd0;
    end else if (target != sel_q) begin
      sel_d   = target;
      pc_d    = 1'b1;
      dwell_d = 16'd0;
`ifdef DISPLAY_7S_PAGE_BLANK_EN
      state_d = ST_BLANK;
      bcnt_d  = 16'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= 3'd0;
      pc_q    <= 1'b0;
      dwell_q <= 16'd0;
    end else begin
      sel_q   <= sel_d;
      pc_q    <= pc_d;
      dwell_q <= dwell_d;
    end
  end

`ifdef DISPLAY_7S_PAGE_BLANK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SHOW;
      bcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign io.blank = (state_q == ST_BLANK);
`else
  assign io.blank = 1'b0;
`endif

  assign io.sel         = sel_q;
  assign io.page_change = pc_q;

endmodule

// File: tb/tb_display_7s_page_ctrl.sv
// Bench for display_7s_page_ctrl: directed scenarios with literal expectations plus random traffic against a behavioural model.
module tb_display_7s_page_ctrl;

  localparam int DWELL = 3;
  localparam int BLANKT = 2;
`ifdef DISPLAY_7S_PAGE_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
  localparam int EXTRA = BLANKT;
`else
  localparam bit BLANK_ON = 1'b0;
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  display_7s_page_ctrl_if bus ();

  display_7s_page_ctrl #(.DWELL_TICKS(DWELL), .BLANK_TICKS(BLANKT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sel = 0, m_pc = 0, m_dwell = 0, m_bleft = 0;
  bit m_blanking = 0, m_valid = 0;

  function automatic int m_next(input int s, input logic [7:0] en);
    for (int k = 1; k <= 8; k++) if (en[(s + k) % 8]) return (s + k) % 8;
    return s;
  endfunction

  function automatic int m_prev(input int s, input logic [7:0] en);
    for (int k = 1; k <= 8; k++) if (en[(s + 8 - k) % 8]) return (s + 8 - k) % 8;
    return s;
  endfunction

  always @(posedge clk) begin
    int tgt;
    if (reset) begin
      m_sel = 0; m_pc = 0; m_dwell = 0; m_blanking = 0; m_bleft = 0; m_valid = 1;
    end else begin
      m_pc = 0;
      tgt = m_sel;
      if (m_blanking) begin
        m_dwell = 0;
        if (bus.tick) begin
          m_bleft--;
          if (m_bleft == 0) m_blanking = 0;
        end
      end else begin
        if (bus.ch_en != 0) begin
          if (!bus.ch_en[m_sel])                   tgt = m_next(m_sel, bus.ch_en);
          else if (bus.btn_next && !bus.btn_prev)  tgt = m_next(m_sel, bus.ch_en);
          else if (bus.btn_prev && !bus.btn_next)  tgt = m_prev(m_sel, bus.ch_en);
          else if (bus.auto_en && bus.tick && m_dwell == DWELL - 1) tgt = m_next(m_sel, bus.ch_en);
        end
        if (!bus.auto_en) m_dwell = 0;
        else if (bus.tick) m_dwell = (m_dwell + 1) % DWELL;
      end
      if (bus.ch_en == 0) begin
        m_sel = 0;
        m_dwell = 0;
      end else if (tgt != m_sel) begin
        m_sel = tgt;
        m_pc = 1;
        m_dwell = 0;
        if (BLANK_ON) begin
          m_blanking = 1;
          m_bleft = BLANKT;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model_sel", int'(bus.sel), m_sel);
      chk("model_page_change", int'(bus.page_change), m_pc);
      chk("model_blank", int'(bus.blank), int'(m_blanking));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic t, input logic n, input logic p);
    @(negedge clk);
    bus.tick = t; bus.btn_next = n; bus.btn_prev = p;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic do_reset(input logic [7:0] en);
    @(negedge clk);
    reset = 1'b1; bus.ch_en = en;
    bus.tick = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    @(negedge clk);
    chk("reset_sel", int'(bus.sel), 0);
    chk("reset_page_change", int'(bus.page_change), 0);
    chk("reset_blank", int'(bus.blank), 0);
    reset = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.ch_en = 8'hFF; bus.auto_en = 1'b0;
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;
    repeat (2) @(negedge clk);

    // Walk all eight pages with btn_next.
    do_reset(8'hFF);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0); idle();
      chk("walk_sel", int'(bus.sel), (i + 1) % 8);
      chk("walk_page_change", int'(bus.page_change), 1);
      settle();
    end

    // Sparse mask 1010_0100: forced skip to 2, prev wraps to 7, next wraps to 2 then 5.
    do_reset(8'b1010_0100);
    idle();
    chk("sparse_skip", int'(bus.sel), 2);
    settle();
    cyc(1'b0, 1'b0, 1'b1); idle();
    chk("sparse_prev", int'(bus.sel), 7);
    settle();
    cyc(1'b0, 1'b1, 1'b0); idle();
    chk("sparse_next_wrap", int'(bus.sel), 2);
    settle();
    cyc(1'b0, 1'b1, 1'b0); idle();
    chk("sparse_next", int'(bus.sel), 5);
    settle();

    // Auto-advance every third tick; a button restarts the dwell count.
    bus.auto_en = 1'b1;
    do_reset(8'h03);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); idle();
    chk("dwell_two_ticks", int'(bus.sel), 0);
    cyc(1'b1, 1'b0, 1'b0); idle();
    chk("dwell_expiry_sel", int'(bus.sel), 1);
    chk("dwell_expiry_pc", int'(bus.page_change), 1);
    do_reset(8'h03);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0); idle();
    chk("dwell_btn_sel", int'(bus.sel), 1);
    repeat (2 + EXTRA) cyc(1'b1, 1'b0, 1'b0);
    idle();
    chk("dwell_restart_hold", int'(bus.sel), 1);
    cyc(1'b1, 1'b0, 1'b0); idle();
    chk("dwell_restart_expiry", int'(bus.sel), 0);
    bus.auto_en = 1'b0;

    // Disabling the current page forces a skip; an empty mask parks on 0 silently.
    do_reset(8'h08);
    idle();
    chk("mask_skip_to_3", int'(bus.sel), 3);
    settle();
    @(negedge clk); bus.ch_en = 8'h41;
    idle();
    chk("mask_skip_to_6", int'(bus.sel), 6);
    chk("mask_skip_pc", int'(bus.page_change), 1);
    @(negedge clk); bus.ch_en = 8'h00;
    idle();
    chk("mask_zero_sel", int'(bus.sel), 0);
    chk("mask_zero_pc", int'(bus.page_change), 0);

    // Both buttons together are ignored.
    do_reset(8'hFF);
    cyc(1'b0, 1'b1, 1'b0); idle();
    settle();
    cyc(1'b0, 1'b1, 1'b1); idle();
    chk("both_btn_sel", int'(bus.sel), 1);
    chk("both_btn_pc", int'(bus.page_change), 0);

`ifdef DISPLAY_7S_PAGE_BLANK_EN
    // Blanking lasts two ticks, swallows buttons, and is abandoned by reset.
    do_reset(8'hFF);
    cyc(1'b0, 1'b1, 1'b0); idle();
    chk("blank_enter_sel", int'(bus.sel), 1);
    chk("blank_enter", int'(bus.blank), 1);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b1, 1'b0); idle();
    chk("blank_btn_ignored", int'(bus.sel), 1);
    chk("blank_mid", int'(bus.blank), 1);
    cyc(1'b1, 1'b0, 1'b0); idle();
    chk("blank_exit", int'(bus.blank), 0);
    cyc(1'b0, 1'b1, 1'b0); idle();
    chk("blank_again_sel", int'(bus.sel), 2);
    chk("blank_again", int'(bus.blank), 1);
    do_reset(8'hFF);
`endif

    // Random traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      bus.tick = $urandom_range(0, 1);
      bus.btn_next = ($urandom_range(0, 7) == 0);
      bus.btn_prev = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.ch_en = 8'($urandom);
          1: bus.ch_en = 8'(1 << $urandom_range(0, 7));
          2: bus.ch_en = 8'h00;
          default: bus.ch_en = 8'hFF;
        endcase
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
